// File: rtl/cnt_bcd_fnd_decoder_pkg.sv
// cnt_bcd_fnd_decoder shared types and constants
// FSM encoding, iteration bounds, segment patterns
package cnt_fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ITER    = 7;
  localparam int CNT_MAX = 99;

  // active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // double-dabble correction: +3 to any nibble >= 5
  function automatic logic [7:0] add3(
    input logic [7:0] b
  );
    logic [3:0] hi;
    logic [3:0] lo;
    hi = b[7:4];
    lo = b[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/cnt_bcd_fnd_decoder_if.sv
// cnt_bcd_fnd_decoder bus interface
// input sample handshake plus result handshake
interface cnt_bcd_fnd_decoder_if;

  logic       i_valid;
  logic       o_ready;
  logic [6:0] i_bin;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_bcd_tens;
  logic [3:0] o_bcd_ones;
  logic [6:0] o_seg_tens;
  logic [6:0] o_seg_ones;
  logic       o_err;

  modport master (
    output i_valid, i_bin, i_ready,
    input  o_ready, o_valid,
    input  o_bcd_tens, o_bcd_ones,
    input  o_seg_tens, o_seg_ones,
    input  o_err
  );

  modport slave (
    input  i_valid, i_bin, i_ready,
    output o_ready, o_valid,
    output o_bcd_tens, o_bcd_ones,
    output o_seg_tens, o_seg_ones,
    output o_err
  );

endinterface

// File: rtl/cnt_bcd_fnd_decoder_seg7_enc.sv
// seg7_enc: BCD digit to 7-segment pattern
// dash overrides blank, blank overrides digit
module seg7_enc
  import cnt_fnd_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] pat;

  // pattern select, then apply display polarity
  always_comb begin
    pat = SEG_BLANK;
    if (dash) begin
      pat = SEG_DASH;
    end else if (!blank) begin
      case (digit)
        4'd0:    pat = SEG_0;
        4'd1:    pat = SEG_1;
        4'd2:    pat = SEG_2;
        4'd3:    pat = SEG_3;
        4'd4:    pat = SEG_4;
        4'd5:    pat = SEG_5;
        4'd6:    pat = SEG_6;
        4'd7:    pat = SEG_7;
        4'd8:    pat = SEG_8;
        4'd9:    pat = SEG_9;
        default: pat = SEG_BLANK;
      endcase
    end
    seg = ACTIVE_LOW ? ~pat : pat;
  end

endmodule

// File: rtl/cnt_bcd_fnd_decoder.sv
// cnt_bcd_fnd_decoder: 0..99 binary to BCD + FND
// serial double-dabble, one bit per clock
module cnt_bcd_fnd_decoder
  import cnt_fnd_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit BLANK_LZ       = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  cnt_bcd_fnd_decoder_if.slave bus
);

  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  bin_q;
  logic [7:0]  bcd_q;
  logic [2:0]  iter_q;
  logic        err_q;
  logic [14:0] sh;
  logic [7:0]  bcd_n;
  logic [6:0]  bin_n;
  logic        last;
  logic        tens_blank;
  logic [6:0]  seg_t_n;
  logic [6:0]  seg_o_n;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;
  logic [6:0]  seg_t_q;
  logic [6:0]  seg_o_q;
  logic        oerr_q;

  assign sh    = {add3(bcd_q), bin_q} << 1;
  assign bcd_n = sh[14:7];
  assign bin_n = sh[6:0];
  assign last  = (iter_q == 3'(ITER - 1));

  assign tens_blank = BLANK_LZ && (bcd_n[7:4] == 4'd0);

  seg7_enc #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_tens (
    .digit (bcd_n[7:4]),
    .blank (tens_blank),
    .dash  (err_q),
    .seg   (seg_t_n)
  );

  seg7_enc #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_ones (
    .digit (bcd_n[3:0]),
    .blank (1'b0),
    .dash  (err_q),
    .seg   (seg_o_n)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt   = state;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // capture sample, then shift-add-3 per clock
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      err_q  <= 1'b0;
    end else if (state == IDLE && bus.i_valid) begin
      bin_q  <= bus.i_bin;
      bcd_q  <= '0;
      iter_q <= '0;
      err_q  <= (bus.i_bin > 7'(CNT_MAX));
    end else if (state == SHIFT) begin
      bin_q  <= bin_n;
      bcd_q  <= bcd_n;
      iter_q <= iter_q + 3'd1;
    end
  end

  // result registers load on DONE entry only
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q  <= '0;
      ones_q  <= '0;
      seg_t_q <= SEG_OFF;
      seg_o_q <= SEG_OFF;
      oerr_q  <= 1'b0;
    end else if (state == SHIFT && last) begin
      tens_q  <= err_q ? 4'hF : bcd_n[7:4];
      ones_q  <= err_q ? 4'hF : bcd_n[3:0];
      seg_t_q <= seg_t_n;
      seg_o_q <= seg_o_n;
      oerr_q  <= err_q;
    end
  end

  assign bus.o_bcd_tens = tens_q;
  assign bus.o_bcd_ones = ones_q;
  assign bus.o_seg_tens = seg_t_q;
  assign bus.o_seg_ones = seg_o_q;
  assign bus.o_err      = oerr_q;

endmodule

// File: tb/tb_cnt_bcd_fnd_decoder.sv
// tb_cnt_bcd_fnd_decoder: three parameter builds
// driven in lockstep, checked against arithmetic model
module tb_cnt_bcd_fnd_decoder;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  cnt_bcd_fnd_decoder_if if_a ();
  cnt_bcd_fnd_decoder_if if_b ();
  cnt_bcd_fnd_decoder_if if_c ();

  cnt_bcd_fnd_decoder u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  cnt_bcd_fnd_decoder #(.BLANK_LZ(1'b0)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  cnt_bcd_fnd_decoder #(.SEG_ACTIVE_LOW(1'b1)) u_c (
    .clk   (clk),
    .reset (reset),
    .bus   (if_c.slave)
  );

  logic [6:0] seg_tbl [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // reference: plain decimal arithmetic + lookup
  function automatic logic [22:0] model(
    input int v, input bit blz, input bit al
  );
    logic [3:0] t, o;
    logic [6:0] st, so;
    logic       e;
    e = (v >= 100);
    if (e) begin
      t = 4'hF; o = 4'hF;
      st = 7'h40; so = 7'h40;
    end else begin
      t = 4'(v / 10);
      o = 4'(v % 10);
      st = (blz && t == 0) ? 7'h00 : seg_tbl[t];
      so = seg_tbl[o];
    end
    if (al) begin st = ~st; so = ~so; end
    return {t, o, st, so, e};
  endfunction

  function automatic logic [22:0] obs_a();
    return {if_a.o_bcd_tens, if_a.o_bcd_ones,
            if_a.o_seg_tens, if_a.o_seg_ones,
            if_a.o_err};
  endfunction

  function automatic logic [22:0] obs_b();
    return {if_b.o_bcd_tens, if_b.o_bcd_ones,
            if_b.o_seg_tens, if_b.o_seg_ones,
            if_b.o_err};
  endfunction

  function automatic logic [22:0] obs_c();
    return {if_c.o_bcd_tens, if_c.o_bcd_ones,
            if_c.o_seg_tens, if_c.o_seg_ones,
            if_c.o_err};
  endfunction

  task automatic set_in(
    input logic v, input logic [6:0] b, input logic r
  );
    if_a.i_valid = v; if_a.i_bin = b; if_a.i_ready = r;
    if_b.i_valid = v; if_b.i_bin = b; if_b.i_ready = r;
    if_c.i_valid = v; if_c.i_bin = b; if_c.i_ready = r;
  endtask

  task automatic do_accept(input int v, input logic r);
    @(negedge clk);
    set_in(1'b1, 7'(v), r);
    @(negedge clk);
    set_in(1'b0, 7'($urandom), r);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!if_a.o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b0, 7'd0, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.o_ready !== 1'b1 || if_a.o_valid !== 1'b0)
      $display("FAIL reset_hs: rdy=%b vld=%b want 1/0",
               if_a.o_ready, if_a.o_valid);
    else passes++;
    checks++;
    if (obs_a() !== 23'h0)
      $display("FAIL reset_out_a: got %h want 0", obs_a());
    else passes++;
    checks++;
    if (if_c.o_seg_tens !== 7'h7F || if_c.o_seg_ones !== 7'h7F)
      $display("FAIL reset_seg_c: got %h/%h want 7f/7f",
               if_c.o_seg_tens, if_c.o_seg_ones);
    else passes++;
  endtask

  task automatic test_known();
    int lat;
    do_accept(42, 1'b1);
    checks++;
    if (if_a.o_ready !== 1'b0)
      $display("FAIL accept_busy: rdy=%b want 0", if_a.o_ready);
    else passes++;
    wait_valid(lat);
    checks++;
    if (lat !== 7)
      $display("FAIL latency_42: got %0d want 7", lat);
    else passes++;
    checks++;
    if (obs_a() !== {4'd4, 4'd2, 7'h66, 7'h5B, 1'b0})
      $display("FAIL val_42: got %h want %h", obs_a(),
               {4'd4, 4'd2, 7'h66, 7'h5B, 1'b0});
    else passes++;

    do_accept(7, 1'b1);
    wait_valid(lat);
    checks++;
    if (obs_a() !== {4'd0, 4'd7, 7'h00, 7'h07, 1'b0})
      $display("FAIL val_7_lz: got %h", obs_a());
    else passes++;
    checks++;
    if (if_b.o_seg_tens !== 7'h3F)
      $display("FAIL val_7_nolz: got %h want 3f",
               if_b.o_seg_tens);
    else passes++;
    checks++;
    if (if_c.o_seg_tens !== 7'h7F || if_c.o_seg_ones !== 7'h78)
      $display("FAIL val_7_al: got %h/%h want 7f/78",
               if_c.o_seg_tens, if_c.o_seg_ones);
    else passes++;

    foreach (seg_tbl[k]) begin
      if (k > 1) break;
      do_accept(k == 0 ? 100 : 127, 1'b1);
      wait_valid(lat);
      checks++;
      if (obs_a() !== {4'hF, 4'hF, 7'h40, 7'h40, 1'b1})
        $display("FAIL err_a: got %h", obs_a());
      else passes++;
      checks++;
      if (if_c.o_seg_tens !== 7'h3F || if_c.o_seg_ones !== 7'h3F
          || if_c.o_err !== 1'b1)
        $display("FAIL err_al: got %h/%h e=%b want 3f/3f/1",
                 if_c.o_seg_tens, if_c.o_seg_ones, if_c.o_err);
      else passes++;
    end
  endtask

  task automatic test_stall();
    int lat;
    do_accept(99, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 7)
      $display("FAIL stall_lat: got %0d want 7", lat);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 7'($urandom), 1'b0);
      checks++;
      if (if_a.o_valid !== 1'b1 || if_a.o_ready !== 1'b0 ||
          obs_a() !== {4'd9, 4'd9, 7'h6F, 7'h6F, 1'b0})
        $display("FAIL stall_hold: vld=%b rdy=%b got %h",
                 if_a.o_valid, if_a.o_ready, obs_a());
      else passes++;
      @(negedge clk);
    end
    set_in(1'b0, 7'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (if_a.o_ready !== 1'b1 || if_a.o_valid !== 1'b0 ||
        obs_a() !== {4'd9, 4'd9, 7'h6F, 7'h6F, 1'b0})
      $display("FAIL stall_release: rdy=%b vld=%b got %h",
               if_a.o_ready, if_a.o_valid, obs_a());
    else passes++;
  endtask

  task automatic test_abort();
    bit seen;
    do_accept(55, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (obs_a() !== 23'h0 || if_c.o_seg_ones !== 7'h7F)
      $display("FAIL abort_out: got %h c=%h want 0/7f",
               obs_a(), if_c.o_seg_ones);
    else passes++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if_a.o_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || if_a.o_ready !== 1'b1)
      $display("FAIL abort_valid: seen=%b rdy=%b want 0/1",
               seen, if_a.o_ready);
    else passes++;
  endtask

  task automatic test_random();
    int lat, v;
    for (int n = 0; n < 30; n++) begin
      v = $urandom_range(0, 127);
      do_accept(v, 1'b1);
      wait_valid(lat);
      checks++;
      if (lat !== 7 || obs_a() !== model(v, 1'b1, 1'b0))
        $display("FAIL rand_a v=%0d: lat=%0d got %h want %h",
                 v, lat, obs_a(), model(v, 1'b1, 1'b0));
      else passes++;
      checks++;
      if (obs_b() !== model(v, 1'b0, 1'b0))
        $display("FAIL rand_b v=%0d: got %h want %h",
                 v, obs_b(), model(v, 1'b0, 1'b0));
      else passes++;
      checks++;
      if (obs_c() !== model(v, 1'b1, 1'b1))
        $display("FAIL rand_c v=%0d: got %h want %h",
                 v, obs_c(), model(v, 1'b1, 1'b1));
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int nxt, got, cyc, last_cyc, v, bad, badp;
    nxt = 0; got = 0; cyc = 0; last_cyc = -1;
    bad = 0; badp = 0;
    @(negedge clk);
    while (got < 100 && cyc < 2000) begin
      if (if_a.o_valid) begin
        v = (q.size() > 0) ? q.pop_front() : -1;
        if (obs_a() !== model(v, 1'b1, 1'b0) ||
            obs_b() !== model(v, 1'b0, 1'b0)) begin
          if (bad == 0)
            $display("FAIL sweep v=%0d: got %h want %h",
                     v, obs_a(), model(v, 1'b1, 1'b0));
          bad++;
        end
        if (last_cyc >= 0 && cyc - last_cyc != 9) begin
          if (badp == 0)
            $display("FAIL sweep_period: got %0d want 9",
                     cyc - last_cyc);
          badp++;
        end
        last_cyc = cyc;
        got++;
        set_in(1'b1, 7'($urandom), 1'b1);
      end else if (if_a.o_ready) begin
        if (nxt < 100) begin
          q.push_back(nxt);
          set_in(1'b1, 7'(nxt), 1'b1);
          nxt++;
        end else begin
          set_in(1'b0, 7'd0, 1'b1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    set_in(1'b0, 7'd0, 1'b1);
    checks++;
    if (got !== 100)
      $display("FAIL sweep_count: got %0d want 100", got);
    else passes++;
    checks++;
    if (bad !== 0)
      $display("FAIL sweep_values: got %0d bad want 0", bad);
    else passes++;
    checks++;
    if (badp !== 0)
      $display("FAIL sweep_rate: got %0d bad want 0", badp);
    else passes++;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 7'd0, 1'b1);
    test_reset();
    test_known();
    test_stall();
    test_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cnt_bcd_fnd_decoder.md
Name: cnt_bcd_fnd_decoder

Overview:
Consumer-side decoder for the 7-bit 0~99 counter value. It accepts one binary sample per valid/ready handshake and converts it to two BCD digits with an iterative shift-add-3 (double-dabble), one bit per clock. It then drives two 7-segment (FND) patterns for the board display. It sits between counter_100-style sources and the FND pin driver.

Parameters:
SEG_ACTIVE_LOW, 0, 1 inverts all seven segment outputs (common-anode display).
BLANK_LZ, 1, 1 blanks the tens digit's segments when the tens digit is 0.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
i_valid  input  1  source presents i_bin
o_ready  output  1  block can accept a sample
i_bin  input  7  binary value, legal range 0..99
o_valid  output  1  result available
i_ready  input  1  sink accepts result
o_bcd_tens  output  4  tens BCD digit
o_bcd_ones  output  4  ones BCD digit
o_seg_tens  output  7  tens segments {g,f,e,d,c,b,a}
o_seg_ones  output  7  ones segments {g,f,e,d,c,b,a}
o_err  output  1  captured sample was >= 100

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset values: state IDLE, o_valid=0, o_bcd_tens=o_bcd_ones=0, o_err=0, both seg outputs = blank (all segments off, polarity per SEG_ACTIVE_LOW). o_ready=1 in the first cycle after reset deasserts.
- FSM states:
  - IDLE: o_ready=1. On the edge where i_valid && o_ready, capture i_bin, clear the 8-bit BCD shift register, set iteration count to 0, go to SHIFT.
  - SHIFT: o_ready=0. Each edge: add 3 to any nibble >= 5, then shift {bcd, bin} left by 1. After 7 iterations go to DONE.
  - DONE: o_valid=1. On the edge where o_valid && i_ready, go to IDLE.
- Latency: accept at edge k; iterations at edges k+1..k+7; o_valid is high after edge k+7 (7 cycles).
- Throughput: at most one result per 9 cycles with i_ready tied high. o_ready is not asserted in DONE (no overlap).
- Outputs (BCD, seg, err) are registered and load at the DONE-entry edge. They stay stable while o_valid && !i_ready, and keep the last result after the handshake until the next DONE entry.
- i_valid while o_ready=0 is ignored; i_bin may change freely outside the accept edge.
- Out of range: capture flags err when i_bin >= 100. At DONE: o_err=1, o_bcd_tens=o_bcd_ones=4'hF, both seg outputs = dash (g only, 0x40 active-high).
- Segment map, active-high: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Non-decimal codes map to blank 0x00.
- BLANK_LZ=1 and tens==0 and no err: o_seg_tens=blank; o_bcd_tens stays 0.
- SEG_ACTIVE_LOW=1: bitwise invert of seg outputs only, including their reset values.
- Reset in SHIFT or DONE: aborts; no o_valid for the aborted sample; outputs return to reset values.
- Reset wins over a simultaneous handshake.

Decomposition:
- Shared package cnt_fnd_pkg holds:
  - state encoding (IDLE, SHIFT, DONE);
  - ITER=7 and CNT_MAX=99;
  - SEG_0..SEG_9, SEG_DASH, SEG_BLANK constants.
- One natural sub-module: seg7_enc (combinational 4-bit digit -> 7-bit pattern, polarity parameter), instantiated twice.
- FSM, shift register and handshake stay in the top module.

Test Plan:
- Reset held 3 cycles, then released -> o_valid=0, o_err=0, seg outputs 0x00; o_ready=1 in the next cycle.
- i_bin=42, one-cycle i_valid, i_ready=1 -> o_valid 7 cycles after accept; tens=4, ones=2, seg 0x66/0x5B, o_err=0.
- i_bin=7, BLANK_LZ=1 -> tens=0, ones=7, o_seg_tens=0x00, o_seg_ones=0x07. Same with BLANK_LZ=0 -> o_seg_tens=0x3F.
- i_bin=99, i_ready low for 5 cycles after o_valid -> outputs hold 9/9, 0x6F/0x6F, o_ready=0 throughout; IDLE one cycle after i_ready=1.
- i_bin=100 and i_bin=127 -> o_err=1, BCD 4'hF/4'hF, both seg 0x40. SEG_ACTIVE_LOW=1 build gives 0x3F.
- Reset pulsed at iteration 3 of i_bin=55 -> no o_valid, outputs at reset values. Full counter_100 sweep 0..99 back-to-back -> every result matches value/10 and value%10.
